// File: rtl/glitch_pkg.sv
// Shared definitions for the glitch burst sequencer: state encoding and
// default field widths.
package glitch_pkg;

    localparam int DEF_DELAY_W = 16;
    localparam int DEF_WIDTH_W = 8;
    localparam int DEF_COUNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DELAY = 2'd1,
        ST_PULSE = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

endpackage

// File: rtl/edge_rise.sv
// Rising-edge detector for a level that is already synchronous to clk.
// The history flop resets high so a level held across reset release is not an edge.
module edge_rise (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise
);

    logic din_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            din_d <= 1'b1;
        end else begin
            // NOTE: sequential state is always assigned with <= so every flop
            // samples pre-edge values regardless of statement order.
            din_d <= din;
        end
    end

    assign rise = din & ~din_d;

endmodule

// File: rtl/glitch_sequencer.sv
// Trigger-armed burst generator feeding pwm_glitch: after a programmable delay
// it emits N glitch pulses of W cycles separated by G low cycles.
module glitch_sequencer
    import glitch_pkg::*;
#(
    parameter int DELAY_W = DEF_DELAY_W,
    parameter int WIDTH_W = DEF_WIDTH_W,
    parameter int COUNT_W = DEF_COUNT_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               trig_in,
    input  logic               abort,
    input  logic [DELAY_W-1:0] cfg_delay,
    input  logic [WIDTH_W-1:0] cfg_width,
    input  logic [WIDTH_W-1:0] cfg_gap,
    input  logic [COUNT_W-1:0] cfg_count,
    output logic               glitch,
    output logic               busy,
    output logic               done,
    output logic [COUNT_W-1:0] shot_cnt
);

    state_t             state;
    logic [DELAY_W-1:0] cnt;
    logic [WIDTH_W-1:0] sh_width;
    logic [WIDTH_W-1:0] sh_gap;
    logic [COUNT_W-1:0] sh_count;
    logic               rise;
    logic [DELAY_W-1:0] width_load;
    logic [DELAY_W-1:0] gap_load;
    logic [COUNT_W-1:0] shot_next;

    edge_rise u_trig_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (trig_in),
        .rise  (rise)
    );

    // Reload values for the shared down-counter; a zero width or gap behaves as 1.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // through the block can leave it unassigned and infer a latch.
        width_load = '0;
        gap_load   = '0;
        if (sh_width != '0) width_load = DELAY_W'(sh_width - WIDTH_W'(1));
        if (sh_gap != '0)   gap_load   = DELAY_W'(sh_gap - WIDTH_W'(1));
    end

    assign shot_next = shot_cnt + COUNT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the shadow config registers are reset too; they are few
            // flops and this keeps every output deterministic after reset.
            state    <= ST_IDLE;
            cnt      <= '0;
            sh_width <= '0;
            sh_gap   <= '0;
            sh_count <= '0;
            glitch   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            shot_cnt <= '0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                // shot_cnt is left alone so the LEDs show how far the burst got
                state  <= ST_IDLE;
                cnt    <= '0;
                glitch <= 1'b0;
                busy   <= 1'b0;
            end else begin
                unique case (state)
                    ST_IDLE: begin
                        if (rise && cfg_count != '0) begin
                            sh_width <= cfg_width;
                            sh_gap   <= cfg_gap;
                            sh_count <= cfg_count;
                            cnt      <= cfg_delay;
                            shot_cnt <= '0;
                            busy     <= 1'b1;
                            state    <= ST_DELAY;
                        end
                    end
                    ST_DELAY, ST_GAP: begin
                        if (cnt == '0) begin
                            glitch <= 1'b1;
                            cnt    <= width_load;
                            state  <= ST_PULSE;
                        end else begin
                            cnt <= cnt - DELAY_W'(1);
                        end
                    end
                    ST_PULSE: begin
                        if (cnt == '0) begin
                            glitch   <= 1'b0;
                            shot_cnt <= shot_next;
                            if (shot_next == sh_count) begin
                                busy  <= 1'b0;
                                done  <= 1'b1;
                                state <= ST_IDLE;
                            end else begin
                                cnt   <= gap_load;
                                state <= ST_GAP;
                            end
                        end else begin
                            cnt <= cnt - DELAY_W'(1);
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_glitch_sequencer.sv
// Directed bench for glitch_sequencer: per-edge expected glitch/busy/done
// vectors worked out by hand from the burst timing.
module tb_glitch_sequencer;

    localparam int DELAY_W = 16;
    localparam int WIDTH_W = 8;
    localparam int COUNT_W = 4;

    logic               clk;
    logic               rst_n;
    logic               trig_in;
    logic               abort;
    logic [DELAY_W-1:0] cfg_delay;
    logic [WIDTH_W-1:0] cfg_width;
    logic [WIDTH_W-1:0] cfg_gap;
    logic [COUNT_W-1:0] cfg_count;
    logic               glitch;
    logic               busy;
    logic               done;
    logic [COUNT_W-1:0] shot_cnt;

    int n_checks = 0;
    int n_errors = 0;

    glitch_sequencer #(
        .DELAY_W (DELAY_W),
        .WIDTH_W (WIDTH_W),
        .COUNT_W (COUNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .trig_in   (trig_in),
        .abort     (abort),
        .cfg_delay (cfg_delay),
        .cfg_width (cfg_width),
        .cfg_gap   (cfg_gap),
        .cfg_count (cfg_count),
        .glitch    (glitch),
        .busy      (busy),
        .done      (done),
        .shot_cnt  (shot_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One active edge, then settle to the falling edge for sampling/driving.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_cfg(input int d, input int w, input int g, input int n);
        cfg_delay = DELAY_W'(d);
        cfg_width = WIDTH_W'(w);
        cfg_gap   = WIDTH_W'(g);
        cfg_count = COUNT_W'(n);
    endtask

    // Drop trig_in for one edge, load config, raise trig_in so the next edge is E0.
    task automatic arm(input int d, input int w, input int g, input int n);
        trig_in = 1'b0;
        tick();
        set_cfg(d, w, g, n);
        trig_in = 1'b1;
    endtask

    // Bit i of each vector is the value expected just after edge Ei.
    task automatic run_seq(input string name, input int n_edges, input logic [31:0] eg,
                           input logic [31:0] eb, input logic [31:0] ed, input bit disturb);
        for (int i = 0; i < n_edges; i++) begin
            tick();
            check($sformatf("%s glitch e%0d", name, i), 32'(glitch), 32'(eg[i]));
            check($sformatf("%s busy e%0d", name, i), 32'(busy), 32'(eb[i]));
            check($sformatf("%s done e%0d", name, i), 32'(done), 32'(ed[i]));
            if (disturb && i == 1) trig_in = 1'b0;
            if (disturb && i == 2) begin
                trig_in = 1'b1;
                set_cfg(0, 7, 4, 5);
            end
        end
    endtask

    initial begin
        logic seen_glitch;
        logic seen_busy;
        logic seen_done;

        rst_n   = 1'b0;
        trig_in = 1'b0;
        abort   = 1'b0;
        set_cfg(0, 0, 0, 0);
        tick();
        tick();
        check("reset glitch", 32'(glitch), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset shot_cnt", 32'(shot_cnt), 32'd0);
        rst_n = 1'b1;
        tick();

        // Basic burst D=3 W=2 G=1 N=2: high after E4,E5,E7,E8; done at E9.
        arm(3, 2, 1, 2);
        run_seq("basic", 11, 32'h1B0, 32'h1FF, 32'h200, 1'b0);
        check("basic shot_cnt", 32'(shot_cnt), 32'd2);

        // trig_in still high from the burst: hold 100 cycles, nothing may happen.
        seen_glitch = 1'b0;
        seen_busy   = 1'b0;
        seen_done   = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            seen_glitch |= glitch;
            seen_busy   |= busy;
            seen_done   |= done;
        end
        check("held glitch", 32'(seen_glitch), 32'd0);
        check("held busy", 32'(seen_busy), 32'd0);
        check("held done", 32'(seen_done), 32'd0);
        check("held shot_cnt", 32'(shot_cnt), 32'd2);

        // Second rise and new config mid-burst must not alter the waveform.
        arm(3, 2, 1, 2);
        run_seq("retrig", 11, 32'h1B0, 32'h1FF, 32'h200, 1'b1);
        check("retrig shot_cnt", 32'(shot_cnt), 32'd2);

        // Zero values D=0 W=0 G=0 N=3: glitch 1,0,1,0,1,0 from E1, done at E6.
        arm(0, 0, 0, 3);
        run_seq("zero", 8, 32'h2A, 32'h3F, 32'h40, 1'b0);
        check("zero shot_cnt", 32'(shot_cnt), 32'd3);

        // N=0: a rise is ignored entirely.
        arm(5, 1, 1, 0);
        run_seq("n0", 4, 32'h0, 32'h0, 32'h0, 1'b0);
        check("n0 shot_cnt", 32'(shot_cnt), 32'd3);

        // Abort during the second pulse of D=0 W=2 G=1 N=3 (second pulse starts E4).
        arm(0, 2, 1, 3);
        run_seq("abort", 5, 32'h16, 32'h1F, 32'h0, 1'b0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort glitch", 32'(glitch), 32'd0);
        check("abort busy", 32'(busy), 32'd0);
        check("abort done", 32'(done), 32'd0);
        check("abort shot_cnt", 32'(shot_cnt), 32'd1);
        seen_glitch = 1'b0;
        seen_done   = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            seen_glitch |= glitch;
            seen_done   |= done;
        end
        check("abort no restart", 32'(seen_glitch), 32'd0);
        check("abort no done", 32'(seen_done), 32'd0);

        // Abort on the same edge as a rise: no burst starts.
        arm(0, 1, 1, 2);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort+rise busy", 32'(busy), 32'd0);
        tick();
        tick();
        check("abort+rise glitch", 32'(glitch), 32'd0);
        check("abort+rise busy later", 32'(busy), 32'd0);
        check("abort+rise shot_cnt", 32'(shot_cnt), 32'd1);

        // Reset mid-pulse drops glitch without a clock edge.
        arm(0, 5, 1, 1);
        tick();
        tick();
        check("pre-reset glitch", 32'(glitch), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async reset glitch", 32'(glitch), 32'd0);
        check("async reset busy", 32'(busy), 32'd0);
        check("async reset shot_cnt", 32'(shot_cnt), 32'd0);
        tick();
        rst_n = 1'b1;
        seen_busy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            seen_busy |= busy;
        end
        check("held through reset busy", 32'(seen_busy), 32'd0);
        check("held through reset glitch", 32'(glitch), 32'd0);

        // Fresh rise after trig_in fell: burst D=0 W=5 N=1 runs and completes.
        arm(0, 5, 1, 1);
        run_seq("post-reset", 8, 32'h3E, 32'h3F, 32'h40, 1'b0);
        check("post-reset shot_cnt", 32'(shot_cnt), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
